// File: rtl/prog_loader.sv
// Program loader for the single-cycle MIPS core.
// Accepts instruction words over a valid/ready stream, writes them into the
// core's instruction memory, and holds the core in reset until the program
// is complete plus a programmable settling time.
module prog_loader #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int RESET_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_RUN,
        ST_ERROR
    } state_t;

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [7:0]        HOLD_INI = 8'(RESET_HOLD);

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [7:0]        hold_cnt;
    logic              accept_p0;

    // The loader is ready exactly while loading; a word moves when valid meets ready.
    always_comb begin
        s_ready   = (state == ST_LOAD);
        accept_p0 = s_valid & s_ready;
    end

    // Control FSM plus the registered write port towards instruction memory.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            hold_cnt   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            // ---- write stage: accepted word appears on the memory port one cycle later
            imem_we <= accept_p0;
            if (accept_p0) begin
                imem_addr  <= wr_ptr;
                imem_wdata <= s_data;
                wr_ptr     <= wr_ptr + PTR_ONE;
                word_count <= word_count + CNT_ONE;
            end

            case (state)
                ST_IDLE, ST_RUN, ST_ERROR: begin
                    if (load_start) begin
                        state      <= ST_LOAD;
                        wr_ptr     <= '0;
                        word_count <= '0;
                        error      <= 1'b0;
                        cpu_reset  <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept_p0) begin
                        if (s_last) begin
                            state    <= ST_HOLD;
                            hold_cnt <= HOLD_INI;
                        end else if (wr_ptr == PTR_LAST) begin
                            // Memory is full but the program claims more words.
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == 8'd1) begin
                        state     <= ST_RUN;
                        hold_cnt  <= '0;
                        cpu_reset <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cpu_reset <= 1'b1;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: one full-size instance (ADDR_W=8) for the
// normal flows and a tiny instance (ADDR_W=2) for overflow and exact fit.
module tb_prog_loader;

    localparam int AW_A = 8;
    localparam int AW_B = 2;
    localparam int DW   = 32;
    localparam int RH   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic            a_load_start, a_s_valid, a_s_last, a_s_ready, a_imem_we;
    logic [DW-1:0]   a_s_data, a_imem_wdata;
    logic [AW_A-1:0] a_imem_addr;
    logic            a_cpu_reset, a_done, a_error;
    logic [AW_A:0]   a_word_count;

    logic            b_load_start, b_s_valid, b_s_last, b_s_ready, b_imem_we;
    logic [DW-1:0]   b_s_data, b_imem_wdata;
    logic [AW_B-1:0] b_imem_addr;
    logic            b_cpu_reset, b_done, b_error;
    logic [AW_B:0]   b_word_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    prog_loader #(.ADDR_W(AW_A), .DATA_W(DW), .RESET_HOLD(RH)) dut_a (
        .clk(clk), .reset(reset), .load_start(a_load_start),
        .s_valid(a_s_valid), .s_data(a_s_data), .s_last(a_s_last), .s_ready(a_s_ready),
        .imem_we(a_imem_we), .imem_addr(a_imem_addr), .imem_wdata(a_imem_wdata),
        .cpu_reset(a_cpu_reset), .done(a_done), .error(a_error), .word_count(a_word_count)
    );

    prog_loader #(.ADDR_W(AW_B), .DATA_W(DW), .RESET_HOLD(RH)) dut_b (
        .clk(clk), .reset(reset), .load_start(b_load_start),
        .s_valid(b_s_valid), .s_data(b_s_data), .s_last(b_s_last), .s_ready(b_s_ready),
        .imem_we(b_imem_we), .imem_addr(b_imem_addr), .imem_wdata(b_imem_wdata),
        .cpu_reset(b_cpu_reset), .done(b_done), .error(b_error), .word_count(b_word_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        a_load_start = 0; a_s_valid = 0; a_s_last = 0; a_s_data = '0;
        b_load_start = 0; b_s_valid = 0; b_s_last = 0; b_s_data = '0;
        step();
        step();
        total_cnt++;
        if (a_s_ready !== 1'b0 || a_imem_we !== 1'b0 || a_imem_addr !== 8'd0 || a_imem_wdata !== 32'd0 ||
            a_cpu_reset !== 1'b1 || a_done !== 1'b0 || a_error !== 1'b0 || a_word_count !== 9'd0)
            $display("FAIL reset_a: rdy=%b we=%b addr=%0d wd=%h crst=%b done=%b err=%b wc=%0d expected 0 0 0 0 1 0 0 0",
                     a_s_ready, a_imem_we, a_imem_addr, a_imem_wdata, a_cpu_reset, a_done, a_error, a_word_count);
        else pass_cnt++;
        total_cnt++;
        if (b_s_ready !== 1'b0 || b_imem_we !== 1'b0 || b_cpu_reset !== 1'b1 || b_error !== 1'b0 || b_word_count !== 3'd0)
            $display("FAIL reset_b: rdy=%b we=%b crst=%b err=%b wc=%0d expected 0 0 1 0 0",
                     b_s_ready, b_imem_we, b_cpu_reset, b_error, b_word_count);
        else pass_cnt++;
        reset = 1'b1;
        // Stream inputs are ignored while idle.
        a_s_valid = 1; a_s_data = 32'hCAFEF00D; a_s_last = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            total_cnt++;
            if (a_imem_we !== 1'b0 || a_s_ready !== 1'b0 || a_word_count !== 9'd0 || a_cpu_reset !== 1'b1)
                $display("FAIL idle_ignore[%0d]: we=%b rdy=%b wc=%0d crst=%b expected 0 0 0 1",
                         k, a_imem_we, a_s_ready, a_word_count, a_cpu_reset);
            else pass_cnt++;
        end
        a_s_valid = 0; a_s_last = 0;
    endtask

    task automatic test_basic();
        logic [31:0] words [3];
        words[0] = 32'h20080005; words[1] = 32'h21080001; words[2] = 32'h08000001;
        a_load_start = 1; step(); a_load_start = 0;
        total_cnt++;
        if (a_s_ready !== 1'b1 || a_cpu_reset !== 1'b1 || a_done !== 1'b0 || a_word_count !== 9'd0)
            $display("FAIL basic_start: rdy=%b crst=%b done=%b wc=%0d expected 1 1 0 0",
                     a_s_ready, a_cpu_reset, a_done, a_word_count);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            a_s_valid = 1; a_s_data = words[i]; a_s_last = (i == 2);
            step();
            total_cnt++;
            if (a_imem_we !== 1'b1 || a_imem_addr !== 8'(i) || a_imem_wdata !== words[i])
                $display("FAIL basic_write[%0d]: we=%b addr=%0d data=%h expected 1 %0d %h",
                         i, a_imem_we, a_imem_addr, a_imem_wdata, i, words[i]);
            else pass_cnt++;
        end
        a_s_valid = 0; a_s_last = 0;
        total_cnt++;
        if (a_word_count !== 9'd3 || a_s_ready !== 1'b0 || a_cpu_reset !== 1'b1)
            $display("FAIL basic_hold_entry: wc=%0d rdy=%b crst=%b expected 3 0 1", a_word_count, a_s_ready, a_cpu_reset);
        else pass_cnt++;
        for (int k = 2; k <= 4; k++) begin
            step();
            total_cnt++;
            if (a_cpu_reset !== 1'b1 || a_done !== 1'b0 || a_imem_we !== 1'b0)
                $display("FAIL basic_hold[N+%0d]: crst=%b done=%b we=%b expected 1 0 0", k, a_cpu_reset, a_done, a_imem_we);
            else pass_cnt++;
        end
        step();
        total_cnt++;
        if (a_cpu_reset !== 1'b0 || a_done !== 1'b1 || a_error !== 1'b0 || a_word_count !== 9'd3)
            $display("FAIL basic_release: crst=%b done=%b err=%b wc=%0d expected 0 1 0 3",
                     a_cpu_reset, a_done, a_error, a_word_count);
        else pass_cnt++;
    endtask

    task automatic test_ignored_run();
        a_s_valid = 1; a_s_data = 32'hDEADDEAD; a_s_last = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            total_cnt++;
            if (a_imem_we !== 1'b0 || a_done !== 1'b1 || a_s_ready !== 1'b0 || a_word_count !== 9'd3)
                $display("FAIL run_ignore[%0d]: we=%b done=%b rdy=%b wc=%0d expected 0 1 0 3",
                         k, a_imem_we, a_done, a_s_ready, a_word_count);
            else pass_cnt++;
        end
        a_s_valid = 0; a_s_last = 0;
    endtask

    task automatic test_reload();
        a_load_start = 1; step(); a_load_start = 0;
        total_cnt++;
        if (a_cpu_reset !== 1'b1 || a_done !== 1'b0 || a_word_count !== 9'd0 || a_s_ready !== 1'b1)
            $display("FAIL reload_start: crst=%b done=%b wc=%0d rdy=%b expected 1 0 0 1",
                     a_cpu_reset, a_done, a_word_count, a_s_ready);
        else pass_cnt++;
        a_s_valid = 1; a_s_data = 32'hDEADBEEF; a_s_last = 1;
        step();
        a_s_valid = 0; a_s_last = 0;
        total_cnt++;
        if (a_imem_we !== 1'b1 || a_imem_addr !== 8'd0 || a_imem_wdata !== 32'hDEADBEEF || a_word_count !== 9'd1)
            $display("FAIL reload_write: we=%b addr=%0d data=%h wc=%0d expected 1 0 deadbeef 1",
                     a_imem_we, a_imem_addr, a_imem_wdata, a_word_count);
        else pass_cnt++;
        for (int k = 2; k <= 4; k++) begin
            step();
            total_cnt++;
            if (a_cpu_reset !== 1'b1 || a_done !== 1'b0)
                $display("FAIL reload_hold[N+%0d]: crst=%b done=%b expected 1 0", k, a_cpu_reset, a_done);
            else pass_cnt++;
        end
        step();
        total_cnt++;
        if (a_cpu_reset !== 1'b0 || a_done !== 1'b1)
            $display("FAIL reload_release: crst=%b done=%b expected 0 1", a_cpu_reset, a_done);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [5:0] vld_pat;
        int exp_addr;
        vld_pat = 6'b101001;   // bit i = s_valid in cycle i: 1,0,0,1,0,1
        exp_addr = 0;
        a_load_start = 1; step(); a_load_start = 0;
        for (int i = 0; i < 6; i++) begin
            a_s_valid    = vld_pat[i];
            a_s_data     = 32'hA0000000 + 32'(exp_addr);
            a_s_last     = (i == 5);
            a_load_start = (i == 1);   // must be ignored while loading
            step();
            a_load_start = 0;
            total_cnt++;
            if (a_imem_we !== vld_pat[i])
                $display("FAIL bp_we[%0d]: we=%b expected %b", i, a_imem_we, vld_pat[i]);
            else pass_cnt++;
            if (vld_pat[i]) exp_addr++;
            total_cnt++;
            if (a_imem_addr !== 8'(exp_addr - 1) || a_imem_wdata !== 32'hA0000000 + 32'(exp_addr - 1))
                $display("FAIL bp_addr[%0d]: addr=%0d data=%h expected %0d %h", i, a_imem_addr, a_imem_wdata,
                         exp_addr - 1, 32'hA0000000 + 32'(exp_addr - 1));
            else pass_cnt++;
            total_cnt++;
            if (a_s_ready !== (i < 5))
                $display("FAIL bp_ready[%0d]: rdy=%b expected %b", i, a_s_ready, (i < 5));
            else pass_cnt++;
        end
        a_s_valid = 0; a_s_last = 0;
        total_cnt++;
        if (a_word_count !== 9'd3)
            $display("FAIL bp_count: wc=%0d expected 3", a_word_count);
        else pass_cnt++;
        repeat (4) step();
        total_cnt++;
        if (a_done !== 1'b1 || a_cpu_reset !== 1'b0)
            $display("FAIL bp_release: done=%b crst=%b expected 1 0", a_done, a_cpu_reset);
        else pass_cnt++;
    endtask

    task automatic test_reset_midload();
        a_load_start = 1; step(); a_load_start = 0;
        a_s_valid = 1; a_s_last = 0; a_s_data = 32'h11110000;
        step();
        a_s_data = 32'h11110001;
        step();
        a_s_data = 32'h11110002;
        reset = 1'b0;
        step();
        reset = 1'b1;
        total_cnt++;
        if (a_imem_we !== 1'b0 || a_imem_addr !== 8'd0 || a_imem_wdata !== 32'd0 || a_cpu_reset !== 1'b1 ||
            a_done !== 1'b0 || a_error !== 1'b0 || a_word_count !== 9'd0 || a_s_ready !== 1'b0)
            $display("FAIL midload_reset: we=%b addr=%0d wd=%h crst=%b done=%b err=%b wc=%0d rdy=%b expected 0 0 0 1 0 0 0 0",
                     a_imem_we, a_imem_addr, a_imem_wdata, a_cpu_reset, a_done, a_error, a_word_count, a_s_ready);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            step();
            total_cnt++;
            if (a_imem_we !== 1'b0 || a_s_ready !== 1'b0 || a_word_count !== 9'd0)
                $display("FAIL midload_idle[%0d]: we=%b rdy=%b wc=%0d expected 0 0 0", k, a_imem_we, a_s_ready, a_word_count);
            else pass_cnt++;
        end
        a_s_valid = 0;
    endtask

    task automatic test_overflow();
        b_load_start = 1; step(); b_load_start = 0;
        for (int i = 0; i < 4; i++) begin
            b_s_valid = 1; b_s_last = 0; b_s_data = 32'hB0000000 + 32'(i);
            step();
            total_cnt++;
            if (b_imem_we !== 1'b1 || b_imem_addr !== 2'(i) || b_imem_wdata !== 32'hB0000000 + 32'(i) || b_error !== (i == 3))
                $display("FAIL ovf_write[%0d]: we=%b addr=%0d data=%h err=%b expected 1 %0d %h %b",
                         i, b_imem_we, b_imem_addr, b_imem_wdata, b_error, i, 32'hB0000000 + 32'(i), (i == 3));
            else pass_cnt++;
        end
        total_cnt++;
        if (b_s_ready !== 1'b0 || b_word_count !== 3'd4 || b_cpu_reset !== 1'b1 || b_done !== 1'b0)
            $display("FAIL ovf_state: rdy=%b wc=%0d crst=%b done=%b expected 0 4 1 0",
                     b_s_ready, b_word_count, b_cpu_reset, b_done);
        else pass_cnt++;
        b_s_data = 32'hB0000004;
        step();
        total_cnt++;
        if (b_imem_we !== 1'b0 || b_imem_addr !== 2'd3 || b_error !== 1'b1 || b_cpu_reset !== 1'b1 || b_s_ready !== 1'b0)
            $display("FAIL ovf_fifth: we=%b addr=%0d err=%b crst=%b rdy=%b expected 0 3 1 1 0",
                     b_imem_we, b_imem_addr, b_error, b_cpu_reset, b_s_ready);
        else pass_cnt++;
        b_s_valid = 0;
        step();
        total_cnt++;
        if (b_error !== 1'b1 || b_word_count !== 3'd4)
            $display("FAIL ovf_sticky: err=%b wc=%0d expected 1 4", b_error, b_word_count);
        else pass_cnt++;
    endtask

    task automatic test_exact_fit();
        b_load_start = 1; step(); b_load_start = 0;
        total_cnt++;
        if (b_error !== 1'b0 || b_word_count !== 3'd0 || b_s_ready !== 1'b1)
            $display("FAIL fit_start: err=%b wc=%0d rdy=%b expected 0 0 1", b_error, b_word_count, b_s_ready);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            b_s_valid = 1; b_s_last = (i == 3); b_s_data = 32'hC0000000 + 32'(i);
            step();
            total_cnt++;
            if (b_imem_we !== 1'b1 || b_imem_addr !== 2'(i) || b_imem_wdata !== 32'hC0000000 + 32'(i))
                $display("FAIL fit_write[%0d]: we=%b addr=%0d data=%h expected 1 %0d %h",
                         i, b_imem_we, b_imem_addr, b_imem_wdata, i, 32'hC0000000 + 32'(i));
            else pass_cnt++;
        end
        b_s_valid = 0; b_s_last = 0;
        total_cnt++;
        if (b_word_count !== 3'd4 || b_error !== 1'b0 || b_s_ready !== 1'b0 || b_cpu_reset !== 1'b1)
            $display("FAIL fit_hold: wc=%0d err=%b rdy=%b crst=%b expected 4 0 0 1",
                     b_word_count, b_error, b_s_ready, b_cpu_reset);
        else pass_cnt++;
        repeat (4) step();
        total_cnt++;
        if (b_done !== 1'b1 || b_cpu_reset !== 1'b0 || b_error !== 1'b0)
            $display("FAIL fit_release: done=%b crst=%b err=%b expected 1 0 0", b_done, b_cpu_reset, b_error);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignored_run();
        test_reload();
        test_backpressure();
        test_reset_midload();
        test_overflow();
        test_exact_fit();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Guard against the run stalling for any reason.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Streaming program loader that writes a MIPS program into the single-cycle core's instruction memory through a valid/ready word interface, while holding the core in reset. It is the writer side of the instruction-memory interface that the core's fetch stage reads. After the last word is written and a programmable hold time elapses, it releases the core's reset. It sits between the host/bench stimulus and MIPS_SingleCycle (imem write port plus core reset).

Parameters:
ADDR_W, 8, word-address width; DEPTH = 2**ADDR_W instruction words.
DATA_W, 32, instruction word width.
RESET_HOLD, 4, cycles the core reset stays asserted after the final write (range 1..255).

Ports:
clk  input  1  clock, all logic on rising edge.
reset  input  1  synchronous, active-low reset of this block.
load_start  input  1  one-cycle pulse; begins a new load (accepted in IDLE, RUN, ERROR).
s_valid  input  1  host word valid.
s_data  input  DATA_W  instruction word.
s_last  input  1  marks final word of the program; qualified by s_valid.
s_ready  output  1  loader accepts a word this cycle.
imem_we  output  1  instruction-memory write enable (registered).
imem_addr  output  ADDR_W  word index written; byte address = imem_addr*4, formed by the memory.
imem_wdata  output  DATA_W  word written.
cpu_reset  output  1  active-high reset to MIPS_SingleCycle.
done  output  1  high while the core is released and running.
error  output  1  sticky overflow flag.
word_count  output  ADDR_W+1  words written in the current/last load.

Behaviour:
- Reset (reset=0 at a rising edge): state IDLE, s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, error=0, word_count=0, hold counter=0.
- States: IDLE, LOAD, HOLD, RUN, ERROR.
- IDLE: cpu_reset=1, s_ready=0. load_start -> LOAD; write pointer and word_count cleared to 0, error cleared.
- LOAD: s_ready=1 (combinational from state, independent of s_valid). Handshake = s_valid & s_ready.
  - Handshake in cycle N -> imem_we=1, imem_addr=pointer, imem_wdata=s_data in cycle N+1; pointer and word_count increment at the same edge.
  - No handshake -> imem_we=0 next cycle; imem_addr/imem_wdata hold their last value.
  - Handshake with s_last=1 -> HOLD; hold counter loaded with RESET_HOLD.
  - Handshake at pointer=DEPTH-1 with s_last=0 -> word still written, error=1, state ERROR (overflow).
  - Handshake at pointer=DEPTH-1 with s_last=1 -> normal completion, no error.
  - load_start in LOAD ignored.
- HOLD: s_ready=0, cpu_reset=1; counter decrements each cycle; at 1 -> RUN. With final handshake in cycle N, cpu_reset first reads 0 and done first reads 1 in cycle N+1+RESET_HOLD.
- RUN: cpu_reset=0, done=1, s_ready=0. load_start -> LOAD; cpu_reset=1 and done=0 from the next cycle, pointer/word_count cleared.
- ERROR: cpu_reset=1, done=0, s_ready=0, error=1 held; load_start -> LOAD (clears error).
- s_valid/s_last/s_data ignored outside LOAD. s_data must be stable only when handshaking.
- Reset mid-operation (any state): immediate return to reset values at that edge; any pending write is dropped (imem_we=0 the following cycle). Memory contents are untouched.
- word_count saturates by construction at DEPTH (ADDR_W+1 bits); it holds after completion until the next load_start.

Test Plan:
- Basic load, ADDR_W=8, RESET_HOLD=4: load_start, then 3 back-to-back words 0x20080005, 0x21080001, 0x08000001 (last on third, handshake cycle N) -> writes at addr 0,1,2 in cycles N-1..N+1, word_count=3, cpu_reset falls and done rises in cycle N+5, error=0.
- Backpressure/gaps: s_valid toggled 1,0,0,1,0,1(last) -> exactly 3 writes, each one cycle after its handshake, imem_we=0 in gap cycles, addresses contiguous 0,1,2.
- Overflow, ADDR_W=2: 5 words, none last -> addr 0..3 written, error=1 in the cycle after 4th handshake, state ERROR, 5th word not accepted (s_ready=0), cpu_reset stays 1; exact-fit 4 words with last on 4th -> no error, done asserts.
- Reload from RUN: after done=1, pulse load_start -> cpu_reset=1, done=0 next cycle; load 1 word 0xDEADBEEF -> written at addr 0, word_count=1, release after RESET_HOLD.
- Reset mid-load: assert reset=0 for one edge after 2 of 4 words -> all outputs at reset values next cycle, cpu_reset=1, state IDLE; s_valid held high is not accepted until a new load_start.
- Ignored inputs: s_valid=1 with data in IDLE and RUN, load_start during LOAD -> no writes, no state change, pointer unaffected.
